// File: rtl/cnn_seq_pkg.sv
// ============================================================================
// Module : cnn_seq_pkg
// Brief  : Stage/state encodings and helpers for the CNN layer sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cnn_seq_pkg;

    localparam int N_STAGES = 6;

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_CONV1 = 3'd1,
        S_POOL1 = 3'd2,
        S_CONV2 = 3'd3,
        S_POOL2 = 3'd4,
        S_FC    = 3'd5
    } stage_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_GUARD = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_ADV   = 3'd5,
        ST_FIN   = 3'd6
    } seq_state_t;

    // Kernel passes for a stage; only the conv stages repeat.
    function automatic int npass(input stage_t s, input int n_conv1, input int n_conv2);
        case (s)
            S_CONV1: return n_conv1;
            S_CONV2: return n_conv2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [N_STAGES-1:0] stage_onehot(input stage_t s);
        logic [N_STAGES-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cnn_layer_sequencer_watchdog.sv
// ============================================================================
// Module : seq_watchdog
// Brief  : Clearable cycle counter flagging the increment that reaches limit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_watchdog #(
    parameter int TW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    input  logic [TW-1:0] limit,
    output logic          expire
);

    logic [TW-1:0] r_count;
    logic [TW:0]   w_count_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + {{(TW-1){1'b0}}, 1'b1};
        end
    end

    // Compared one bit wider so a limit of all-ones cannot alias on wrap.
    assign w_count_next = {1'b0, r_count} + {{TW{1'b0}}, 1'b1};
    assign expire       = inc && (w_count_next == {1'b0, limit});

endmodule

`default_nettype wire

// File: rtl/cnn_layer_sequencer.sv
// ============================================================================
// Module : cnn_layer_sequencer
// Brief  : Steps LOAD..FC stages: clear, run counters, drain; host handshake.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cnn_layer_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int NPASS_CONV1 = 2,
    parameter int NPASS_CONV2 = 4,
    parameter int DRAIN_CYC   = 3,
    parameter int TIMEOUT     = 1023,
    parameter int TW          = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                img_valid,
    input  logic [N_STAGES-1:0] stage_done,
    output logic [N_STAGES-1:0] cnt_clr,
    output logic [N_STAGES-1:0] cnt_en,
    output logic [2:0]          stage,
    output logic [1:0]          pass,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam logic [TW-1:0] C_TIMEOUT_LIM = TW'(TIMEOUT);
    localparam logic [TW-1:0] C_DRAIN_LIM   = TW'(DRAIN_CYC);

    seq_state_t          r_state;
    seq_state_t          w_next_state;
    stage_t              r_stage;
    stage_t              w_next_stage;
    logic [1:0]          r_pass;
    logic [1:0]          w_next_pass;
    logic [N_STAGES-1:0] r_cnt_clr;
    logic [N_STAGES-1:0] r_cnt_en;
    logic [N_STAGES-1:0] w_en_mask;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic                w_timeout;
    logic                w_wd_hit;
    logic                w_wd_expire;
    logic                w_drain_expire;
    logic                w_more_passes;

    seq_watchdog #(.TW(TW)) u_run_wd (
        .clk    (clk),
        .reset  (reset),
        .clr    (r_state == ST_CLR),
        .inc    (r_state == ST_RUN),
        .limit  (C_TIMEOUT_LIM),
        .expire (w_wd_hit)
    );

    seq_watchdog #(.TW(TW)) u_drain_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (r_state != ST_DRAIN),
        .inc    (r_state == ST_DRAIN),
        .limit  (C_DRAIN_LIM),
        .expire (w_drain_expire)
    );

    assign w_wd_expire   = (TIMEOUT != 0) && w_wd_hit;
    assign w_more_passes = (int'(r_pass) + 1) < npass(r_stage, NPASS_CONV1, NPASS_CONV2);

    always_comb begin
        w_next_state = r_state;
        w_next_stage = r_stage;
        w_next_pass  = r_pass;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_CLR;
                    w_next_stage = S_LOAD;
                    w_next_pass  = 2'd0;
                end
            end
            ST_CLR:   w_next_state = ST_GUARD;
            ST_GUARD: w_next_state = ST_RUN;
            ST_RUN: begin
                // A done flag sampled in the same cycle as expiry takes priority.
                if (stage_done[r_stage]) begin
                    if (r_stage == S_LOAD || DRAIN_CYC == 0) begin
                        w_next_state = ST_ADV;
                    end else begin
                        w_next_state = ST_DRAIN;
                    end
                end else if (w_wd_expire) begin
                    w_next_state = ST_FIN;
                    w_timeout    = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_drain_expire) begin
                    w_next_state = ST_ADV;
                end
            end
            ST_ADV: begin
                if (w_more_passes) begin
                    w_next_pass  = r_pass + 2'd1;
                    w_next_state = ST_CLR;
                end else if (r_stage == S_FC) begin
                    w_next_state = ST_FIN;
                end else begin
                    w_next_stage = stage_t'(r_stage + 3'd1);
                    w_next_pass  = 2'd0;
                    w_next_state = ST_CLR;
                end
            end
            ST_FIN: begin
                w_next_state = ST_IDLE;
                w_next_stage = S_LOAD;
                w_next_pass  = 2'd0;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_stage = S_LOAD;
                w_next_pass  = 2'd0;
            end
        endcase
    end

    // LOAD only advances its address counter on accepted pixels.
    always_comb begin
        w_en_mask = stage_onehot(w_next_stage);
        if (w_next_stage == S_LOAD && !img_valid) begin
            w_en_mask = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_stage   <= S_LOAD;
            r_pass    <= 2'd0;
            r_cnt_clr <= '0;
            r_cnt_en  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_stage   <= w_next_stage;
            r_pass    <= w_next_pass;
            r_cnt_clr <= (w_next_state == ST_CLR) ? stage_onehot(w_next_stage) : '0;
            r_cnt_en  <= (w_next_state == ST_RUN) ? w_en_mask : '0;
            r_busy    <= (w_next_state != ST_IDLE) && (w_next_state != ST_FIN);
            r_done    <= (w_next_state == ST_FIN);
            if (r_state == ST_IDLE && start) begin
                r_error <= 1'b0;
            end else if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    assign cnt_clr = r_cnt_clr;
    assign cnt_en  = r_cnt_en;
    assign stage   = r_stage;
    assign pass    = r_pass;
    assign busy    = r_busy;
    assign done    = r_done;
    assign error   = r_error;

endmodule

`default_nettype wire

// File: tb/tb_cnn_layer_sequencer.sv
// ============================================================================
// Module : tb_cnn_layer_sequencer
// Brief  : Directed self-checking bench with behavioural counter sets.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cnn_layer_sequencer;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       start     = 1'b0;
    logic       img_valid = 1'b1;
    logic [5:0] stage_done;
    logic [5:0] cnt_clr;
    logic [5:0] cnt_en;
    logic [2:0] stage;
    logic [1:0] pass;
    logic       busy;
    logic       done;
    logic       error;

    always #5 clk = ~clk;

    cnn_layer_sequencer #(
        .NPASS_CONV1 (2),
        .NPASS_CONV2 (4),
        .DRAIN_CYC   (3),
        .TIMEOUT     (20),
        .TW          (10)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .img_valid  (img_valid),
        .stage_done (stage_done),
        .cnt_clr    (cnt_clr),
        .cnt_en     (cnt_en),
        .stage      (stage),
        .pass       (pass),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Counter-set model: done after 5 enabled cycles since the last clear.
    logic [7:0] en_cnt [6] = '{default: 8'd0};
    logic [5:0] hang       = '0;
    logic [5:0] force_hi   = '0;

    always @(posedge clk) begin
        for (int s = 0; s < 6; s++) begin
            if (cnt_clr[s]) begin
                en_cnt[s] <= 8'd0;
            end else if (cnt_en[s] && en_cnt[s] != 8'hff) begin
                en_cnt[s] <= en_cnt[s] + 8'd1;
            end
        end
    end

    always_comb begin
        stage_done = '0;
        for (int s = 0; s < 6; s++) begin
            stage_done[s] = force_hi[s] | (!hang[s] && en_cnt[s] >= 8'd5);
        end
    end

    int n_busy      = 0;
    int n_done      = 0;
    int n_inv       = 0;
    int n_done_busy = 0;
    int en_cyc [6]  = '{default: 0};
    int clr_log [$];

    always @(negedge clk) begin
        if (busy) n_busy++;
        if (done) n_done++;
        if (done && busy) n_done_busy++;
        if (!$onehot0(cnt_clr | cnt_en) || (cnt_clr & cnt_en) != 6'd0) n_inv++;
        for (int s = 0; s < 6; s++) begin
            if (cnt_en[s]) en_cyc[s]++;
            if (cnt_clr[s]) clr_log.push_back(s * 4 + int'(pass));
        end
    end

    int n_run  = 0;
    int n_fail = 0;
    int exp_seq [10] = '{0, 4, 5, 8, 12, 13, 14, 15, 16, 20};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic check_seq(input string tag, input int base);
        check({tag, "_len"}, clr_log.size() - base, 10);
        if (clr_log.size() >= base + 10) begin
            for (int i = 0; i < 10; i++) begin
                check(tag, clr_log[base + i], exp_seq[i]);
            end
        end
    endtask

    initial begin
        int b_busy, b_done, b_log, b_en;
        int ones, mism;

        repeat (3) @(negedge clk);
        check("rst_outs", 32'({cnt_clr, cnt_en, stage, pass, busy, done, error}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_outs", 32'({cnt_clr, cnt_en, stage, pass, busy, done, error}), 32'd0);

        // Full inference with default behaviour
        b_busy = n_busy; b_done = n_done; b_log = clr_log.size(); b_en = en_cyc[5];
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_clr_load", 32'(cnt_clr), 32'h01);
        wait_done("t1_done", 400);
        check("t1_busy_at_done", 32'(busy), 32'd0);
        check("t1_error", 32'(error), 32'd0);
        check("t1_stage_fin", 32'(stage), 32'd5);
        @(negedge clk);
        check("t1_idle_stage", 32'(stage), 32'd0);
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_busy_cycles", n_busy - b_busy, 117);
        check("t1_done_count", n_done - b_done, 1);
        check("t1_fc_en_cycles", en_cyc[5] - b_en, 6);
        check_seq("t1_clr_seq", b_log);

        // Start while busy is ignored
        b_busy = n_busy; b_done = n_done; b_log = clr_log.size();
        pulse_start();
        for (int k = 0; k < 400 && !(cnt_en[3] && pass == 2'd1); k++) @(negedge clk);
        check("t2_reach", 32'({cnt_en[3], pass}), 32'd5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t2_stage_hold", 32'(stage), 32'd3);
        check("t2_pass_hold", 32'(pass), 32'd1);
        wait_done("t2_done", 400);
        @(negedge clk);
        check("t2_busy_cycles", n_busy - b_busy, 117);
        check("t2_done_count", n_done - b_done, 1);
        check_seq("t2_clr_seq", b_log);

        // Asynchronous reset during CONV2 pass 2 drain
        pulse_start();
        for (int k = 0; k < 400 && !(cnt_en[3] && pass == 2'd2); k++) @(negedge clk);
        for (int k = 0; k < 20 && cnt_en != 6'd0; k++) @(negedge clk);
        check("t3_in_drain", 32'({cnt_clr, cnt_en, stage, pass}), 32'({12'd0, 3'd3, 2'd2}));
        #2 reset = 1'b1;
        #1;
        check("t3_async_rst", 32'({cnt_clr, cnt_en, stage, pass, busy, done, error}), 32'd0);
        @(negedge clk);
        check("t3_rst_hold", 32'({cnt_clr, cnt_en, stage, pass, busy, done, error}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        b_done = n_done; b_log = clr_log.size();
        pulse_start();
        check("t3_replay_clr", 32'(cnt_clr), 32'h01);
        check("t3_replay_pass", 32'(pass), 32'd0);
        wait_done("t3_done", 400);
        @(negedge clk);
        check("t3_done_count", n_done - b_done, 1);
        check_seq("t3_clr_seq", b_log);

        // Watchdog expiry in POOL1
        hang[2] = 1'b1;
        b_busy = n_busy; b_done = n_done; b_en = en_cyc[2];
        pulse_start();
        wait_done("t4_done", 400);
        check("t4_error", 32'(error), 32'd1);
        check("t4_en_off", 32'(cnt_en), 32'd0);
        check("t4_stage", 32'(stage), 32'd2);
        check("t4_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("t4_error_sticky", 32'(error), 32'd1);
        check("t4_busy_cycles", n_busy - b_busy, 55);
        check("t4_run_cycles", en_cyc[2] - b_en, 20);
        check("t4_done_count", n_done - b_done, 1);
        hang[2] = 1'b0;
        pulse_start();
        check("t4_error_clear", 32'(error), 32'd0);
        check("t4_restart_busy", 32'(busy), 32'd1);
        wait_done("t4_done2", 400);
        check("t4_error_final", 32'(error), 32'd0);
        @(negedge clk);

        // LOAD with toggling img_valid and a hung LOAD counter
        hang[0] = 1'b1;
        img_valid = 1'b1;
        pulse_start();
        check("t5_clr", 32'(cnt_clr), 32'h01);
        ones = 0;
        mism = 0;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("t5_guard_en", 32'(cnt_en), 32'd0);
            end else begin
                if (cnt_en[0] !== img_valid) mism++;
                ones += int'(cnt_en[0]);
            end
            img_valid = ~img_valid;
        end
        @(negedge clk);
        check("t5_done", 32'(done), 32'd1);
        check("t5_error", 32'(error), 32'd1);
        check("t5_mirror", mism, 0);
        check("t5_en_ones", ones, 10);
        hang[0] = 1'b0;
        img_valid = 1'b1;
        @(negedge clk);

        // CONV1 done held high across CLR/GUARD
        force_hi[1] = 1'b1;
        b_busy = n_busy; b_en = en_cyc[1];
        pulse_start();
        wait_done("t6_done", 400);
        check("t6_error", 32'(error), 32'd0);
        @(negedge clk);
        check("t6_busy_cycles", n_busy - b_busy, 107);
        check("t6_conv1_en", en_cyc[1] - b_en, 2);
        force_hi[1] = 1'b0;

        check("inv_onehot", n_inv, 0);
        check("done_with_busy", n_done_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
